// File: rtl/cache_fill_if.sv
// Cache-side and memory-side handshake bundle for the line-fill controller.
interface cache_fill_if #(
    parameter int ADDR_W = 16
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [15:0]       memory_data_in;
    logic              fsm_busy;
    logic              mem_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [ADDR_W-1:0] cache_word_addr;
    logic [15:0]       cache_data;
    logic              write_tag_array;
    logic [ADDR_W-1:0] tag_address;

    // Controller side: consumes the miss and memory returns, drives memory and cache writes.
    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data_in,
        output fsm_busy, mem_en, memory_address, write_data_array,
               cache_word_addr, cache_data, write_tag_array, tag_address
    );

    // Environment side: cache and main memory.
    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data_in,
        input  fsm_busy, mem_en, memory_address, write_data_array,
               cache_word_addr, cache_data, write_tag_array, tag_address
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss line-fill controller: issues BLOCK_WORDS pipelined reads for the
// missed line and streams each returned word into the cache data array.
//
//   state | meaning
//   IDLE  | waiting for a miss; memory returns are ignored
//   FILL  | issuing reads and writing returned words; tag written with last word
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    cache_fill_if.master bus
);
    localparam int OFF_BITS = $clog2(BLOCK_WORDS) + 1;
    localparam int CNT_W    = $clog2(BLOCK_WORDS) + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF_BITS) - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;

    logic issuing;
    logic receiving;
    logic last_word;

    // Byte address of word cnt within the line; base is aligned so no carry leaves the line.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] line_base,
                                                    input logic [CNT_W-1:0]  cnt);
        return line_base + (ADDR_W'(cnt) << 1);
    endfunction

    assign issuing   = (state == FILL) && (issue_cnt < CNT_FULL);
    assign receiving = (state == FILL) && bus.memory_data_valid;
    assign last_word = receiving && (recv_cnt == CNT_LAST);

    // Fill sequencing: latch the line once per miss, count issues and returns independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_detected) begin
                        base      <= bus.miss_address & ALIGN_MASK;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (issuing)   issue_cnt <= issue_cnt + CNT_W'(1);
                    if (receiving) recv_cnt  <= recv_cnt + CNT_W'(1);
                    if (last_word) state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fsm_busy         = (state == FILL);
    assign bus.mem_en           = issuing;
    assign bus.memory_address   = issuing ? word_addr(base, issue_cnt) : '0;
    assign bus.tag_address      = base;
    assign bus.write_data_array = receiving;
    assign bus.cache_word_addr  = receiving ? word_addr(base, recv_cnt) : '0;
    assign bus.cache_data       = bus.memory_data_in;
    assign bus.write_tag_array  = last_word;
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the CPU's instruction/data caches and the shared multi-cycle main memory. When a cache reports a miss, the block fetches the 8-word (16-byte) line containing the missed address from main memory. It streams each returned word into the cache data array and writes the tag once the last word lands. `fsm_busy` stalls the pipeline for the whole fill.

## Interface
Parameters:
- `BLOCK_WORDS`, 8: words per cache line. Must be a power of two.
- `ADDR_W`, 16: byte-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss_detected`  in  1  level; the cache requests a line fill.
- `miss_address`  in  ADDR_W  byte address that missed. Sampled only when a miss is accepted.
- `memory_data_valid`  in  1  main memory returns one word this cycle.
- `memory_data_in`  in  16  returned word.
- `fsm_busy`  out  1  fill in progress; the pipeline stalls while high.
- `mem_en`  out  1  issue a read to main memory this cycle.
- `memory_address`  out  ADDR_W  byte address of the read being issued.
- `write_data_array`  out  1  write `cache_data` into the data array at `cache_word_addr`.
- `cache_word_addr`  out  ADDR_W  byte address of the word being written.
- `cache_data`  out  16  word to write. Equal to `memory_data_in`.
- `write_tag_array`  out  1  one-cycle pulse: commit tag/valid for `tag_address`.
- `tag_address`  out  ADDR_W  line base address of the current fill.

## Operation
- States: IDLE and FILL. Internal registers:
  - `base`: the latched line base.
  - `issue_cnt`, 0..BLOCK_WORDS: counts reads issued.
  - `recv_cnt`, 0..BLOCK_WORDS: counts words received.
- IDLE, `miss_detected`=1:
  - `base` <= `miss_address` with the low log2(BLOCK_WORDS)+1 bits cleared.
  - Both counters <= 0.
  - Next state FILL.
- IDLE, `miss_detected`=0: stay in IDLE.
- In IDLE, `memory_data_valid` is ignored: no writes, no counting.
- FILL, read issue:
  - `mem_en`=1 while `issue_cnt` < BLOCK_WORDS.
  - `memory_address` = `base` + 2*`issue_cnt`.
  - `issue_cnt` increments each such cycle.
  - One request per cycle; the memory is pipelined and never back-pressures.
- FILL, data receive, on each `memory_data_valid`=1:
  - `write_data_array`=1 and `cache_data`=`memory_data_in`.
  - `cache_word_addr` = `base` + 2*`recv_cnt`.
  - `recv_cnt` increments.
- Words return in issue order. The block counts valids, not cycles, so it is latency-agnostic.
- Final word (`recv_cnt`==BLOCK_WORDS-1 and `memory_data_valid`=1):
  - `write_tag_array`=1 in the same cycle.
  - Next state IDLE.
- `miss_detected` and `miss_address` are ignored while in FILL. The address is latched once.
- `fsm_busy` = (state==FILL).
- Address arithmetic is modulo 2^ADDR_W. `base` is aligned, so no carry crosses the line boundary.
- Reset mid-fill: next cycle state=IDLE, counters=0, all outputs at their reset values. Main memory shares `rst`, so no stale returns follow.

## Timing
- Reset values: `fsm_busy`, `mem_en`, `write_data_array`, `write_tag_array` = 0. `memory_address`, `cache_word_addr`, `tag_address` = 0. `cache_data` follows `memory_data_in`.
- Source of each output:
  - `fsm_busy`, `mem_en`, `memory_address`, `tag_address` are decoded from registered state only.
  - `write_data_array`, `write_tag_array`, `cache_word_addr`, `cache_data` are combinational from `memory_data_valid` / `memory_data_in` plus registered state.
  - No path from `miss_detected` to any output.
- Cycle sequence, with the miss sampled at edge 0 and memory latency L:
  - `fsm_busy`=1 from cycle 1.
  - Reads issue in cycles 1..8.
  - Valids arrive in cycles 1+L..8+L.
  - `write_tag_array` fires at cycle 8+L.
  - `fsm_busy`=0 at cycle 9+L.
- Total stall for L=4: 12 cycles.
- Back-to-back misses: a miss held high across the return to IDLE is accepted on the first IDLE edge. That gives one idle cycle between fills.
- Gaps in `memory_data_valid` only extend FILL. Nothing else changes.

## Test plan
- Basic fill: reset, then `miss_address`=0x1236 with L=4 and data 0xA000+i.
  - `memory_address` = 0x1230..0x123E in cycles 1..8.
  - Writes to 0x1230..0x123E with 0xA000..0xA007 in cycles 5..12.
  - `write_tag_array` at cycle 12 with `tag_address`=0x1230; busy drops at cycle 13.
- Wrap at top of memory: `miss_address`=0xFFFF.
  - `base`=0xFFF0; addresses 0xFFF0..0xFFFE; no overflow into 0x0000.
- Irregular returns: valids with 1–3 idle cycles between them.
  - Exactly 8 writes at consecutive word addresses; tag pulse coincides with the 8th valid.
- Ignored inputs:
  - `miss_address` changes and `miss_detected` toggles during FILL: `base` unchanged, no restart.
  - Stray valid in IDLE: no write.
- Reset mid-fill: assert `rst` in cycle 6.
  - Cycle 7: IDLE, all outputs 0.
  - A new miss at 0x0040 then fills correctly from 0x0040.
- Back-to-back misses: `miss_detected` held high through two fills.
  - Second fill starts exactly one cycle after `fsm_busy` falls and uses the address present at that edge.
